// File: rtl/oam_dma.sv
// Sprite-DMA initiator: copies one 256-byte CPU page into OAM while holding the CPU.
// Optional macro OAM_DMA_ALIGN_EN adds a parity flop and an ALIGN cycle after HALT.
module oam_dma (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  page,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_data_in,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we_n,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done
);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic        dma_rd_q, dma_rd_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_data_q, oam_data_d;
    logic        oam_we_n_q, oam_we_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef OAM_DMA_ALIGN_EN
    logic        parity_q;
`endif

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        done_d     = 1'b0;
        dma_addr_d = 16'h0000;
        dma_rd_d   = 1'b0;
        oam_addr_d = 8'h00;
        oam_data_d = 8'h00;
        oam_we_n_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    page_d  = page;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? ALIGN : READ;
`else
                state_d = READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: state_d = READ;
`endif
            READ: begin
                data_d  = dma_data_in;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        if (state_d == READ) begin
            dma_rd_d   = 1'b1;
            dma_addr_d = {page_d, idx_d};
        end
        if (state_d == WRITE) begin
            oam_we_n_d = 1'b0;
            oam_addr_d = idx_d;
            oam_data_d = data_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            data_q     <= 8'h00;
            dma_addr_q <= 16'h0000;
            dma_rd_q   <= 1'b0;
            oam_addr_q <= 8'h00;
            oam_data_q <= 8'h00;
            oam_we_n_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            dma_addr_q <= dma_addr_d;
            dma_rd_q   <= dma_rd_d;
            oam_addr_q <= oam_addr_d;
            oam_data_q <= oam_data_d;
            oam_we_n_q <= oam_we_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef OAM_DMA_ALIGN_EN
            parity_q   <= ~parity_q;
`endif
        end
    end

    assign dma_addr = dma_addr_q;
    assign dma_rd   = dma_rd_q;
    assign oam_addr = oam_addr_q;
    assign oam_data = oam_data_q;
    assign oam_we_n = oam_we_n_q;
    assign cpu_halt = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: negedge RAM model, OAM model and per-transfer monitor.
module tb_oam_dma;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [7:0]  page;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_data_in;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_we_n;
    logic        cpu_halt;
    logic        busy;
    logic        done;

    always #5 Clk = ~Clk;

    oam_dma dut (
        .Clk(Clk), .Reset(Reset), .start(start), .page(page),
        .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_data_in(dma_data_in),
        .oam_addr(oam_addr), .oam_data(oam_data), .oam_we_n(oam_we_n),
        .cpu_halt(cpu_halt), .busy(busy), .done(done)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] ram [2048];
    logic [7:0] ram_q = 8'h00;
    logic [7:0] oam [256];
    logic [7:0] exp_page = 8'h00;
    logic       tb_par = 1'b0;

    // Per-transfer monitor state, cleared when busy rises.
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, busy_cnt = 0, idle_busy = 0;
    int          order_err = 0, addr_err = 0, consec_err = 0, done_cnt = 0;
    int          last_wr_cyc = 0, done_gap = 0;
    logic [15:0] last_rd = 16'h0;
    logic        halt_par = 1'b0, prev_busy = 1'b0, prev_we = 1'b0;

    function automatic logic [7:0] exp_byte(input logic [7:0] pg, input logic [7:0] i);
        return i ^ 8'hA5 ^ {pg[2:0] ^ 3'd2, 5'b00000};
    endfunction

    function automatic int exp_len();
`ifdef OAM_DMA_ALIGN_EN
        return 513 + int'(halt_par);
`else
        return 513;
`endif
    endfunction

    function automatic int exp_idle();
`ifdef OAM_DMA_ALIGN_EN
        return 1 + int'(halt_par);
`else
        return 1;
`endif
    endfunction

    always @(posedge Clk) tb_par <= Reset ? 1'b0 : ~tb_par;

    always @(negedge Clk) ram_q <= ram[dma_addr[10:0]];
    assign dma_data_in = ram_q;

    always @(negedge Clk) begin
        cyc++;
        if (busy && !prev_busy) begin
            wr_cnt = 0; rd_cnt = 0; busy_cnt = 0; idle_busy = 0;
            order_err = 0; addr_err = 0; consec_err = 0; done_cnt = 0;
            halt_par = tb_par;
        end
        prev_busy = busy;
        if (busy) begin
            busy_cnt++;
            if (!dma_rd && oam_we_n) idle_busy++;
        end
        if (dma_rd) begin
            if (dma_addr !== {exp_page, rd_cnt[7:0]}) addr_err++;
            last_rd = dma_addr;
            rd_cnt++;
        end
        if (!oam_we_n) begin
            if (oam_addr != wr_cnt[7:0]) order_err++;
            if (prev_we) consec_err++;
            oam[oam_addr] = oam_data;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        prev_we = !oam_we_n;
        if (done) begin
            done_cnt++;
            done_gap = cyc - last_wr_cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_oam(input string tag, input logic [7:0] pg, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i <= hi; i++)
            if (oam[i] !== exp_byte(pg, 8'(i))) bad++;
        check(tag, 64'(bad), 64'(0));
    endtask

    task automatic pulse_start(input logic [7:0] pg);
        start = 1'b1;
        page  = pg;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge Clk); #1;
            if (done) begin ok = 1'b1; break; end
        end
        check(tag, 64'(ok), 64'(1));
    endtask

    task automatic wait_read(input string tag, input logic [7:0] b);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge Clk); #1;
            if (dma_rd && dma_addr[7:0] == b) begin ok = 1'b1; break; end
        end
        check(tag, 64'(ok), 64'(1));
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] pg);
        check({tag, "_writes"}, 64'(wr_cnt), 64'(256));
        check({tag, "_order"}, 64'(order_err), 64'(0));
        check({tag, "_addr"}, 64'(addr_err), 64'(0));
        check({tag, "_consec_we"}, 64'(consec_err), 64'(0));
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'(exp_len()));
        check({tag, "_idle_busy"}, 64'(idle_busy), 64'(exp_idle()));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        check({tag, "_done_gap"}, 64'(done_gap), 64'(1));
        check_oam({tag, "_oam"}, pg, 0, 255);
    endtask

    localparam logic [37:0] RST_VALS = {16'h0000, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        for (int a = 0; a < 2048; a++) ram[a] = exp_byte(8'(a >> 8), 8'(a));
        Reset = 1'b1; start = 1'b0; page = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs", 64'({dma_addr, dma_rd, oam_addr, oam_data, oam_we_n, cpu_halt, busy, done}),
              64'(RST_VALS));
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("idle_no_start", 64'({busy, cpu_halt}), 64'(0));

        // Basic copy from page 0x02
        exp_page = 8'h02;
        pulse_start(8'h02);
        check("halt_cycle", 64'({busy, cpu_halt, dma_rd, oam_we_n}), 64'(4'b1101));
        wait_done("basic_timeout");
        check("basic_done_busy", 64'(busy), 64'(0));
        @(posedge Clk); #1;
        check("basic_done_pulse", 64'(done), 64'(0));
        check_xfer("basic", 8'h02);

        // High page: no carry out of the low byte
        exp_page = 8'h07;
        pulse_start(8'h07);
        wait_done("high_timeout");
        @(posedge Clk); #1;
        check_xfer("high", 8'h07);
        check("high_last_addr", 64'(last_rd), 64'(16'h07FF));
        check("high_reads", 64'(rd_cnt), 64'(256));

        // Start while busy is ignored
        exp_page = 8'h03;
        pulse_start(8'h03);
        wait_read("busy_wait40", 8'd40);
        pulse_start(8'h05);
        wait_done("busy_timeout");
        @(posedge Clk); #1;
        check_xfer("ignore", 8'h03);
        repeat (3) @(posedge Clk);
        #1;
        check("ignore_no_restart", 64'(busy), 64'(0));

        // Reset in the READ cycle of byte 100
        exp_page = 8'h07;
        pulse_start(8'h07);
        wait_read("rst_wait100", 8'd100);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("midreset_outputs", 64'({dma_addr, dma_rd, oam_addr, oam_data, oam_we_n, cpu_halt, busy, done}),
              64'(RST_VALS));
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("midreset_idle", 64'(busy), 64'(0));
        check("midreset_writes", 64'(wr_cnt), 64'(100));
        check_oam("midreset_low", 8'h07, 0, 99);
        check_oam("midreset_high", 8'h03, 100, 255);

        // Back-to-back: second start issued in the done cycle
        exp_page = 8'h05;
        pulse_start(8'h05);
        wait_done("b2b_first_timeout");
        exp_page = 8'h03;
        pulse_start(8'h03);
        check("b2b_accept", 64'({busy, dma_rd}), 64'(2'b10));
        wait_done("b2b_second_timeout");
        @(posedge Clk); #1;
        check_xfer("b2b", 8'h03);

`ifdef OAM_DMA_ALIGN_EN
        // HALT on parity 1 inserts ALIGN, parity 0 does not
        exp_page = 8'h02;
        if (tb_par) begin @(posedge Clk); #1; end
        pulse_start(8'h02);
        wait_done("align1_timeout");
        @(posedge Clk); #1;
        check("align1_len", 64'(busy_cnt), 64'(514));
        check("align1_idle", 64'(idle_busy), 64'(2));
        check_oam("align1_oam", 8'h02, 0, 255);
        exp_page = 8'h07;
        if (!tb_par) begin @(posedge Clk); #1; end
        pulse_start(8'h07);
        wait_done("align0_timeout");
        @(posedge Clk); #1;
        check("align0_len", 64'(busy_cnt), 64'(513));
        check("align0_idle", 64'(idle_busy), 64'(1));
        check_oam("align0_oam", 8'h07, 0, 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
